// File: rtl/chip8_timer_bank.sv
// CHIP-8 timer bank: fractional phase accumulators for the CPU step and 60 Hz ticks,
// plus NUM_TIMERS loadable down-counters (0 = delay, 1 = sound).

module chip8_phase_acc #(
    parameter int CLK_HZ = 12000000,
    parameter int RATE   = 60
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    output logic o_tick
);
    localparam int AW = $clog2(CLK_HZ + RATE) + 1;
    localparam logic [AW-1:0] LP_CLK  = AW'(CLK_HZ);
    localparam logic [AW-1:0] LP_RATE = AW'(RATE);

    logic [AW-1:0] r_acc;
    logic [AW-1:0] w_nxt;
    logic          w_wrap;

    // r_acc < CLK_HZ always, so the sum never overflows AW bits
    assign w_nxt  = r_acc + LP_RATE;
    assign w_wrap = (w_nxt >= LP_CLK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            o_tick <= 1'b0;
        end else if (i_enable) begin
            r_acc  <= w_wrap ? (w_nxt - LP_CLK) : w_nxt;
            o_tick <= w_wrap;
        end else begin
            o_tick <= 1'b0;
        end
    end
endmodule

module chip8_timer_cell #(
    parameter int TIMER_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_dec,
    input  logic               i_wr,
    input  logic [TIMER_W-1:0] i_wr_data,
    output logic [TIMER_W-1:0] o_value,
    output logic               o_active,
    output logic               o_expired
);
    logic [TIMER_W-1:0] w_nxt;
    logic               w_expire;

    // A load always wins over a same-edge decrement and never counts as expiry
    always_comb begin
        w_nxt    = o_value;
        w_expire = 1'b0;
        if (i_wr) begin
            w_nxt = i_wr_data;
        end else if (i_dec && (o_value != '0)) begin
            w_nxt    = o_value - 1'b1;
            w_expire = (o_value == TIMER_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_value   <= '0;
            o_active  <= 1'b0;
            o_expired <= 1'b0;
        end else begin
            o_value   <= w_nxt;
            o_active  <= (w_nxt != '0);
            o_expired <= w_expire;
        end
    end
endmodule

module chip8_timer_bank #(
    parameter int CLK_HZ     = 12000000,
    parameter int CPU_HZ     = 500,
    parameter int TICK_HZ    = 60,
    parameter int NUM_TIMERS = 2,
    parameter int TIMER_W    = 8,
    parameter int SEL_W      = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  wr_en,
    input  logic [SEL_W-1:0]      wr_sel,
    input  logic [TIMER_W-1:0]    wr_data,
    input  logic [SEL_W-1:0]      rd_sel,
    output logic [TIMER_W-1:0]    rd_data,
    output logic                  timer_cpu_tick,
    output logic                  timer_60hz_tick,
    output logic [NUM_TIMERS-1:0] timer_active,
    output logic [NUM_TIMERS-1:0] expired
);
    logic [NUM_TIMERS-1:0][TIMER_W-1:0] w_val;
    logic [NUM_TIMERS-1:0]              w_wr;
    logic                               w_dec;

    chip8_phase_acc #(.CLK_HZ(CLK_HZ), .RATE(CPU_HZ)) u_cpu_acc (
        .clk      (clk),
        .rst      (rst),
        .i_enable (enable),
        .o_tick   (timer_cpu_tick)
    );

    chip8_phase_acc #(.CLK_HZ(CLK_HZ), .RATE(TICK_HZ)) u_tick_acc (
        .clk      (clk),
        .rst      (rst),
        .i_enable (enable),
        .o_tick   (timer_60hz_tick)
    );

    // Decrement follows the registered tick, one cycle after it is visible
    assign w_dec = timer_60hz_tick & enable;

    for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_timer
        assign w_wr[g] = wr_en && (wr_sel == SEL_W'(g));

        chip8_timer_cell #(.TIMER_W(TIMER_W)) u_cell (
            .clk       (clk),
            .rst       (rst),
            .i_dec     (w_dec),
            .i_wr      (w_wr[g]),
            .i_wr_data (wr_data),
            .o_value   (w_val[g]),
            .o_active  (timer_active[g]),
            .o_expired (expired[g])
        );
    end

    // Out-of-range selects match no timer and read as zero
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (rd_sel == SEL_W'(i)) rd_data = w_val[i];
        end
    end
endmodule
